// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// writeback_arbiter : merges the in-order pipeline result with long-latency
//                     ext channels into one registered register-file write.
// Revision 1.0
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_EXT        = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pipe_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]          pipe_rd_i,
    input  logic [1:0]                         pipe_result_src_i,
    input  logic [DATA_WIDTH-1:0]              pipe_alu_result_i,
    input  logic [DATA_WIDTH-1:0]              pipe_mem_data_i,
    input  logic [DATA_WIDTH-1:0]              pipe_pc_plus_4_i,
    input  logic [2:0]                         pipe_load_fmt_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]    pipe_byte_off_i,
    input  logic [NUM_EXT-1:0]                 ext_valid_i,
    output logic [NUM_EXT-1:0]                 ext_ready_o,
    input  logic [NUM_EXT*REG_ADDR_WIDTH-1:0]  ext_rd_i,
    input  logic [NUM_EXT*DATA_WIDTH-1:0]      ext_data_i,
    output logic                               stall_req_o,
    output logic                               rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]          rf_rd_o,
    output logic [DATA_WIDTH-1:0]              rf_wdata_o
);

    localparam int OFF_W = $clog2(DATA_WIDTH/8);
    localparam int PTR_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_EXT - 1);

    logic                      pipe_used;
    logic [DATA_WIDTH-1:0]     pipe_data;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [OFF_W-1:0]          off_h;
    logic [OFF_W-1:0]          off_w;
    logic [DATA_WIDTH-1:0]     sh_b;
    logic [DATA_WIDTH-1:0]     sh_h;
    logic [DATA_WIDTH-1:0]     sh_w;

    logic                      hi_found;
    logic                      lo_found;
    logic [PTR_W-1:0]          hi_idx;
    logic [PTR_W-1:0]          lo_idx;
    logic                      grant_found;
    logic [PTR_W-1:0]          grant_idx;
    logic                      ext_xfer;
    logic [REG_ADDR_WIDTH-1:0] ext_sel_rd;
    logic [DATA_WIDTH-1:0]     ext_sel_data;

    logic [PTR_W-1:0]          rr_ptr_q;
    logic [PTR_W-1:0]          rr_ptr_d;
    logic                      rf_we_q;
    logic                      rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_rd_q;
    logic [REG_ADDR_WIDTH-1:0] rf_rd_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q;
    logic [DATA_WIDTH-1:0]     rf_wdata_d;
    logic [NUM_EXT-1:0]        starved;

    assign pipe_used = pipe_valid_i && (pipe_rd_i != '0);

    // Offset bits below the access size are dropped so every access is aligned.
    always_comb begin
        off_h = pipe_byte_off_i & ~OFF_W'(1);
        off_w = pipe_byte_off_i & ~OFF_W'(3);
        sh_b  = pipe_mem_data_i >> {pipe_byte_off_i, 3'b000};
        sh_h  = pipe_mem_data_i >> {off_h, 3'b000};
        sh_w  = pipe_mem_data_i >> {off_w, 3'b000};
        case (pipe_load_fmt_i)
            3'b000:  load_data = DATA_WIDTH'($signed(sh_b[7:0]));
            3'b001:  load_data = DATA_WIDTH'($signed(sh_h[15:0]));
            3'b010:  load_data = DATA_WIDTH'($signed(sh_w[31:0]));
            3'b100:  load_data = DATA_WIDTH'(sh_b[7:0]);
            3'b101:  load_data = DATA_WIDTH'(sh_h[15:0]);
            3'b110:  load_data = DATA_WIDTH'(sh_w[31:0]);
            default: load_data = pipe_mem_data_i;
        endcase
    end

    always_comb begin
        case (pipe_result_src_i)
            2'b00:   pipe_data = pipe_alu_result_i;
            2'b01:   pipe_data = load_data;
            2'b10:   pipe_data = pipe_pc_plus_4_i;
            default: pipe_data = '0;
        endcase
    end

    // Round-robin: lowest valid index at/above rr_ptr, else lowest valid below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_EXT - 1; k >= 0; k--) begin
            if (ext_valid_i[k]) begin
                if (k >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(k);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign ext_xfer = grant_found && !pipe_used;

    always_comb begin
        ext_ready_o  = '0;
        ext_sel_rd   = '0;
        ext_sel_data = '0;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (grant_idx == PTR_W'(k)) begin
                ext_sel_rd     = ext_rd_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                ext_sel_data   = ext_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                ext_ready_o[k] = ext_xfer;
            end
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        rr_ptr_d   = rr_ptr_q;
        if (pipe_used) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = pipe_rd_i;
            rf_wdata_d = pipe_data;
        end else if (ext_xfer) begin
            rr_ptr_d = (grant_idx == LAST_PTR) ? '0 : grant_idx + PTR_W'(1);
            // A transfer to x0 still consumes the slot but never writes.
            if (ext_sel_rd != '0) begin
                rf_we_d    = 1'b1;
                rf_rd_d    = ext_sel_rd;
                rf_wdata_d = ext_sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    for (genvar k = 0; k < NUM_EXT; k++) begin : g_starve
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = '0;
            if (ext_valid_i[k] && !ext_ready_o[k]) begin
                cnt_d = (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign starved[k] = (cnt_q == CNT_W'(STARVE_LIMIT));
    end

    assign stall_req_o = |starved;
    assign rf_we_o     = rf_we_q;
    assign rf_rd_o     = rf_rd_q;
    assign rf_wdata_o  = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// tb_writeback_arbiter : directed self-checking bench for writeback_arbiter.
// Revision 1.0
// ============================================================================
module tb_writeback_arbiter;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int NE  = 2;
    localparam int SL  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_valid;
    logic [RAW-1:0]  pipe_rd;
    logic [1:0]      pipe_src;
    logic [DW-1:0]   pipe_alu;
    logic [DW-1:0]   pipe_mem;
    logic [DW-1:0]   pipe_pc4;
    logic [2:0]      pipe_fmt;
    logic [1:0]      pipe_off;
    logic [NE-1:0]   ext_valid;
    logic [NE-1:0]   ext_ready;
    logic [NE*RAW-1:0] ext_rd;
    logic [NE*DW-1:0]  ext_data;
    logic            stall_req;
    logic            rf_we;
    logic [RAW-1:0]  rf_rd;
    logic [DW-1:0]   rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .NUM_EXT(NE), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_valid_i(pipe_valid), .pipe_rd_i(pipe_rd), .pipe_result_src_i(pipe_src),
        .pipe_alu_result_i(pipe_alu), .pipe_mem_data_i(pipe_mem), .pipe_pc_plus_4_i(pipe_pc4),
        .pipe_load_fmt_i(pipe_fmt), .pipe_byte_off_i(pipe_off),
        .ext_valid_i(ext_valid), .ext_ready_o(ext_ready), .ext_rd_i(ext_rd), .ext_data_i(ext_data),
        .stall_req_o(stall_req), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_src = 2'b00; pipe_alu = '0;
        pipe_mem = '0; pipe_pc4 = '0; pipe_fmt = 3'b000; pipe_off = '0;
        ext_valid = '0; ext_rd = '0; ext_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        #3;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", rf_wdata); else n_pass++;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_req); else n_pass++;
        n_checks++; if (ext_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", ext_ready); else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_ext();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_src = 2'b01; pipe_mem = 32'h80FF_1234;
        pipe_fmt = 3'b000; pipe_off = 2'd3;
        step();
        n_checks++; if (rf_we !== 1'b1) $display("FAIL lb_we: got %b expected 1", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd3) $display("FAIL lb_rd: got %0d expected 3", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'hFFFF_FF80) $display("FAIL lb_off3: got %h expected ffffff80", rf_wdata); else n_pass++;
        pipe_fmt = 3'b101; pipe_off = 2'd2;
        step();
        n_checks++; if (rf_wdata !== 32'h0000_80FF) $display("FAIL lhu_off2: got %h expected 000080ff", rf_wdata); else n_pass++;
        pipe_fmt = 3'b001; pipe_off = 2'd3;
        step();
        n_checks++; if (rf_wdata !== 32'hFFFF_80FF) $display("FAIL lh_off3: got %h expected ffff80ff", rf_wdata); else n_pass++;
        pipe_fmt = 3'b100; pipe_off = 2'd1;
        step();
        n_checks++; if (rf_wdata !== 32'h0000_0012) $display("FAIL lbu_off1: got %h expected 00000012", rf_wdata); else n_pass++;
        pipe_fmt = 3'b010; pipe_off = 2'd1;
        step();
        n_checks++; if (rf_wdata !== 32'h80FF_1234) $display("FAIL lw_off1: got %h expected 80ff1234", rf_wdata); else n_pass++;
        pipe_src = 2'b00; pipe_alu = 32'h0000_1111;
        step();
        n_checks++; if (rf_wdata !== 32'h0000_1111) $display("FAIL src_alu: got %h expected 00001111", rf_wdata); else n_pass++;
        pipe_src = 2'b10; pipe_pc4 = 32'h0000_2004;
        step();
        n_checks++; if (rf_wdata !== 32'h0000_2004) $display("FAIL src_pc4: got %h expected 00002004", rf_wdata); else n_pass++;
        pipe_src = 2'b11;
        step();
        n_checks++; if (rf_wdata !== 32'h0) $display("FAIL src_rsvd: got %h expected 0", rf_wdata); else n_pass++;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL src_rsvd_we: got %b expected 1", rf_we); else n_pass++;
        set_idle();
        step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL idle_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd3) $display("FAIL idle_rd_hold: got %0d expected 3", rf_rd); else n_pass++;
    endtask

    task automatic test_pipe_priority();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_src = 2'b00; pipe_alu = 32'h0000_AAAA;
        ext_valid = 2'b01; ext_rd[4:0] = 5'd7; ext_data[31:0] = 32'h0000_7777;
        #1;
        n_checks++; if (ext_ready !== 2'b00) $display("FAIL prio_ready: got %b expected 00", ext_ready); else n_pass++;
        step();
        n_checks++; if (rf_rd !== 5'd5) $display("FAIL prio_rd: got %0d expected 5", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0000_AAAA) $display("FAIL prio_data: got %h expected 0000aaaa", rf_wdata); else n_pass++;
        pipe_valid = 1'b0;
        #1;
        n_checks++; if (ext_ready !== 2'b01) $display("FAIL prio_ext_ready: got %b expected 01", ext_ready); else n_pass++;
        step();
        n_checks++; if (rf_rd !== 5'd7) $display("FAIL prio_ext_rd: got %0d expected 7", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0000_7777) $display("FAIL prio_ext_data: got %h expected 00007777", rf_wdata); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_rd_zero();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_src = 2'b00; pipe_alu = 32'h0000_DEAD;
        ext_valid = 2'b01; ext_rd[4:0] = 5'd9; ext_data[31:0] = 32'h0000_0099;
        #1;
        n_checks++; if (ext_ready !== 2'b01) $display("FAIL rd0_pipe_ready: got %b expected 01", ext_ready); else n_pass++;
        step();
        n_checks++; if (rf_rd !== 5'd9) $display("FAIL rd0_pipe_rd: got %0d expected 9", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0000_0099) $display("FAIL rd0_pipe_data: got %h expected 00000099", rf_wdata); else n_pass++;
        pipe_valid = 1'b0; ext_rd[4:0] = 5'd0; ext_data[31:0] = 32'h0000_0055;
        #1;
        n_checks++; if (ext_ready !== 2'b01) $display("FAIL rd0_ext_ready: got %b expected 01", ext_ready); else n_pass++;
        step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rd0_ext_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0000_0099) $display("FAIL rd0_ext_hold: got %h expected 00000099", rf_wdata); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_reset_mid_write();
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_src = 2'b00; pipe_alu = 32'h0000_0044;
        step();
        n_checks++; if (rf_we !== 1'b1) $display("FAIL mid_pre_we: got %b expected 1", rf_we); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL mid_rst_we: got %b expected 0", rf_we); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0) $display("FAIL mid_rst_data: got %h expected 0", rf_wdata); else n_pass++;
        set_idle();
        ext_valid = 2'b11; ext_rd = {5'd14, 5'd13}; ext_data = {32'h0000_00E1, 32'h0000_00E0};
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (ext_ready !== 2'b01) $display("FAIL mid_first_grant: got %b expected 01", ext_ready); else n_pass++;
        step();
        n_checks++; if (rf_rd !== 5'd13) $display("FAIL mid_first_rd: got %0d expected 13", rf_rd); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0]     exp_ready;
        logic [RAW-1:0] exp_rd;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        ext_valid = 2'b11; ext_rd = {5'd11, 5'd10}; ext_data = {32'h0000_00B1, 32'h0000_00A0};
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd    = (i % 2 == 0) ? 5'd10 : 5'd11;
            n_checks++; if (ext_ready !== exp_ready) $display("FAIL rr_ready_%0d: got %b expected %b", i, ext_ready, exp_ready); else n_pass++;
            step();
            n_checks++; if (rf_we !== 1'b1) $display("FAIL rr_we_%0d: got %b expected 1", i, rf_we); else n_pass++;
            n_checks++; if (rf_rd !== exp_rd) $display("FAIL rr_rd_%0d: got %0d expected %0d", i, rf_rd, exp_rd); else n_pass++;
        end
        set_idle();
        step();
    endtask

    task automatic test_starvation();
        pipe_valid = 1'b1; pipe_rd = 5'd6; pipe_src = 2'b00; pipe_alu = 32'h0000_0066;
        ext_valid = 2'b10; ext_rd[9:5] = 5'd12; ext_data[63:32] = 32'h0000_00C0;
        #1;
        for (int i = 0; i < SL; i++) begin
            n_checks++; if (stall_req !== 1'b0) $display("FAIL starve_pre_%0d: got %b expected 0", i, stall_req); else n_pass++;
            step();
        end
        n_checks++; if (stall_req !== 1'b1) $display("FAIL starve_rise: got %b expected 1", stall_req); else n_pass++;
        step();
        n_checks++; if (stall_req !== 1'b1) $display("FAIL starve_sat: got %b expected 1", stall_req); else n_pass++;
        pipe_valid = 1'b0;
        #1;
        n_checks++; if (ext_ready !== 2'b10) $display("FAIL starve_grant: got %b expected 10", ext_ready); else n_pass++;
        step();
        n_checks++; if (stall_req !== 1'b0) $display("FAIL starve_clear: got %b expected 0", stall_req); else n_pass++;
        n_checks++; if (rf_rd !== 5'd12) $display("FAIL starve_rd: got %0d expected 12", rf_rd); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0000_00C0) $display("FAIL starve_data: got %h expected 000000c0", rf_wdata); else n_pass++;
        set_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_pipe_priority();
        test_rd_zero();
        test_reset_mid_write();
        test_round_robin();
        test_starvation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
